// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared definitions for the GMII loopback emulator.
//                Defines the FIFO entry layout and the playback state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package eth_pkg;

    // FIFO entry layout: {eof, er, data[7:0]}
    localparam int EOF_BIT     = 9;
    localparam int ER_BIT      = 8;
    localparam int ENTRY_W     = 10;

    // Default minimum idle gap between replayed frames
    localparam int IFG_DEFAULT = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } play_state_t;

    // Assemble one FIFO entry from its fields
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic       eof,
        input logic       er,
        input logic [7:0] data
    );
        return {eof, er, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_loop_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : eth_loop_fifo
//  Description : Simple dual-port frame buffer RAM. One write and one
//                registered read per cycle; no pointer logic here.
//  Revision    : 1.0  initial release
// ============================================================================
module eth_loop_fifo #(
    parameter int DEPTH  = 2048,
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port and registered read port; read-during-write returns old data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/eth_gmii_loopback.sv
`default_nettype none
// ============================================================================
//  Module      : eth_gmii_loopback
//  Description : PHY-side GMII loopback. Captures whole frames from gmii_tx*,
//                stores them (store-and-forward) and replays them on gmii_rx*
//                with a minimum inter-frame gap. Optional FCS corruption and
//                rx_er injection on replay.
//  Revision    : 1.0  initial release
// ============================================================================
module eth_gmii_loopback
    import eth_pkg::*;
#(
    parameter int FIFO_DEPTH = 2048,
    parameter int IFG_CYCLES = IFG_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  gmii_txd,
    input  logic        gmii_tx_en,
    input  logic        gmii_tx_er,
    output logic [7:0]  gmii_rxd,
    output logic        gmii_rx_dv,
    output logic        gmii_rx_er,
    input  logic        cfg_enable,
    input  logic        cfg_corrupt_fcs,
    input  logic        cfg_inject_er,
    output logic        loop_busy,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count,
    output logic        overflow
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    // Capture side state
    logic              tx_prev_q,     tx_prev_d;
    logic              cap_active_q,  cap_active_d;
    logic [7:0]        stage_data_q,  stage_data_d;
    logic              stage_er_q,    stage_er_d;
    logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]  wr_commit_q,   wr_commit_d;
    logic [15:0]       drop_count_q,  drop_count_d;
    logic              overflow_q,    overflow_d;

    // Playback side state
    play_state_t       state_q,       state_d;
    logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [GAP_W-1:0]  gap_cnt_q,     gap_cnt_d;
    logic              corrupt_q,     corrupt_d;
    logic              inject_q,      inject_d;
    logic [7:0]        rxd_q,         rxd_d;
    logic              rx_dv_q,       rx_dv_d;
    logic              rx_er_q,       rx_er_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              loop_busy_q,   loop_busy_d;

    // RAM interface
    logic               fifo_we;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               rd_avail;

    assign fifo_full = ((wr_ptr_q - rd_ptr_q) == PTR_W'(FIFO_DEPTH));
    assign rd_avail  = (rd_ptr_q != wr_commit_q);

    // Reading at the next pointer keeps fifo_rdata aligned with rd_ptr_q
    eth_loop_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .WIDTH  (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .wr_en   (fifo_we),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (fifo_wdata),
        .rd_addr (rd_ptr_d[ADDR_W-1:0]),
        .rd_data (fifo_rdata)
    );

    // Capture: stage each byte one cycle so the last one can be tagged eof
    always_comb begin
        tx_prev_d    = gmii_tx_en;
        cap_active_d = cap_active_q;
        stage_data_d = stage_data_q;
        stage_er_d   = stage_er_q;
        wr_ptr_d     = wr_ptr_q;
        wr_commit_d  = wr_commit_q;
        drop_count_d = drop_count_q;
        overflow_d   = 1'b0;
        fifo_we      = 1'b0;
        fifo_wdata   = pack_entry(~gmii_tx_en, stage_er_q, stage_data_q);

        if (cap_active_q) begin
            if (fifo_full) begin
                // Roll back the partial frame and ignore the rest of it
                wr_ptr_d     = wr_commit_q;
                cap_active_d = 1'b0;
                drop_count_d = drop_count_q + 16'd1;
                overflow_d   = 1'b1;
            end else begin
                fifo_we  = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (!gmii_tx_en) begin
                    wr_commit_d  = wr_ptr_q + PTR_W'(1);
                    cap_active_d = 1'b0;
                end else begin
                    stage_data_d = gmii_txd;
                    stage_er_d   = gmii_tx_er;
                end
            end
        end else if (gmii_tx_en && !tx_prev_q && cfg_enable) begin
            cap_active_d = 1'b1;
            stage_data_d = gmii_txd;
            stage_er_d   = gmii_tx_er;
        end
    end

    // Playback FSM: one byte per cycle from the RAM, then an idle gap
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        gap_cnt_d     = gap_cnt_q;
        corrupt_d     = corrupt_q;
        inject_d      = inject_q;
        rxd_d         = 8'd0;
        rx_dv_d       = 1'b0;
        rx_er_d       = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_avail) begin
                    state_d   = ST_PLAY;
                    corrupt_d = cfg_corrupt_fcs;
                    inject_d  = cfg_inject_er;
                end
            end
            ST_PLAY: begin
                rx_dv_d  = 1'b1;
                rxd_d    = fifo_rdata[7:0]
                         ^ {7'd0, fifo_rdata[EOF_BIT] & corrupt_q};
                rx_er_d  = fifo_rdata[ER_BIT] | inject_q;
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (fifo_rdata[EOF_BIT]) begin
                    state_d       = ST_GAP;
                    gap_cnt_d     = '0;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(IFG_CYCLES - 1)) begin
                    if (rd_avail) begin
                        state_d   = ST_PLAY;
                        corrupt_d = cfg_corrupt_fcs;
                        inject_d  = cfg_inject_er;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Busy while a frame is being captured, played, spaced, or waiting
    always_comb begin
        loop_busy_d = cap_active_d || (state_d != ST_IDLE) || (rd_ptr_d != wr_commit_d);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_prev_q     <= 1'b0;
            cap_active_q  <= 1'b0;
            stage_data_q  <= 8'd0;
            stage_er_q    <= 1'b0;
            wr_ptr_q      <= '0;
            wr_commit_q   <= '0;
            drop_count_q  <= 16'd0;
            overflow_q    <= 1'b0;
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            gap_cnt_q     <= '0;
            corrupt_q     <= 1'b0;
            inject_q      <= 1'b0;
            rxd_q         <= 8'd0;
            rx_dv_q       <= 1'b0;
            rx_er_q       <= 1'b0;
            frame_count_q <= 16'd0;
            loop_busy_q   <= 1'b0;
        end else begin
            tx_prev_q     <= tx_prev_d;
            cap_active_q  <= cap_active_d;
            stage_data_q  <= stage_data_d;
            stage_er_q    <= stage_er_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_commit_q   <= wr_commit_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            gap_cnt_q     <= gap_cnt_d;
            corrupt_q     <= corrupt_d;
            inject_q      <= inject_d;
            rxd_q         <= rxd_d;
            rx_dv_q       <= rx_dv_d;
            rx_er_q       <= rx_er_d;
            frame_count_q <= frame_count_d;
            loop_busy_q   <= loop_busy_d;
        end
    end

    assign gmii_rxd    = rxd_q;
    assign gmii_rx_dv  = rx_dv_q;
    assign gmii_rx_er  = rx_er_q;
    assign loop_busy   = loop_busy_q;
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_gmii_loopback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_gmii_loopback
//  Description : Scoreboard bench for eth_gmii_loopback. A large-buffer and a
//                64-entry instance share the TX bus; per-instance enables pick
//                which one captures each frame.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eth_gmii_loopback;

    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  txd;
    logic        tx_en, tx_er;
    logic        en_big, en_small, corrupt, inject;

    logic [7:0]  b_rxd, s_rxd;
    logic        b_dv, b_er, b_busy, b_ovf;
    logic        s_dv, s_er, s_busy, s_ovf;
    logic [15:0] b_fc, b_dc, s_fc, s_dc;

    eth_gmii_loopback #(.FIFO_DEPTH(2048), .IFG_CYCLES(IFG)) u_big (
        .clk(clk), .rst(rst),
        .gmii_txd(txd), .gmii_tx_en(tx_en), .gmii_tx_er(tx_er),
        .gmii_rxd(b_rxd), .gmii_rx_dv(b_dv), .gmii_rx_er(b_er),
        .cfg_enable(en_big), .cfg_corrupt_fcs(corrupt), .cfg_inject_er(inject),
        .loop_busy(b_busy), .frame_count(b_fc), .drop_count(b_dc), .overflow(b_ovf)
    );

    eth_gmii_loopback #(.FIFO_DEPTH(64), .IFG_CYCLES(IFG)) u_small (
        .clk(clk), .rst(rst),
        .gmii_txd(txd), .gmii_tx_en(tx_en), .gmii_tx_er(tx_er),
        .gmii_rxd(s_rxd), .gmii_rx_dv(s_dv), .gmii_rx_er(s_er),
        .cfg_enable(en_small), .cfg_corrupt_fcs(corrupt), .cfg_inject_er(inject),
        .loop_busy(s_busy), .frame_count(s_fc), .drop_count(s_dc), .overflow(s_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected entries {eof, er, data} per instance
    logic [9:0] sb_big[$];
    logic [9:0] sb_small[$];
    bit         in_fr[2];
    bit         seen[2];
    int         gap[2];
    int         ovf_pulses[2];

    task automatic mon(input int k, input logic dv, input logic er,
                       input logic [7:0] d, input logic ovf);
        logic [9:0] e;
        int         depth;
        if (ovf) ovf_pulses[k]++;
        depth = (k == 0) ? sb_big.size() : sb_small.size();
        if (dv) begin
            if (depth == 0) begin
                chk("rx_unexpected", 32'(dv), 32'd0);
            end else begin
                if (k == 0) e = sb_big.pop_front();
                else        e = sb_small.pop_front();
                chk("rx_byte", {23'd0, er, d}, {23'd0, e[8:0]});
                if (!in_fr[k] && seen[k]) chk("ifg_min", 32'(gap[k] >= IFG), 32'd1);
                in_fr[k] = !e[9];
                if (e[9]) seen[k] = 1'b1;
                gap[k] = 0;
            end
        end else begin
            if (in_fr[k]) begin
                chk("rx_dv_bubble", 32'(dv), 32'd1);
                in_fr[k] = 1'b0;
            end
            gap[k]++;
            chk("idle_out_zero", {23'd0, er, d}, 32'd0);
        end
    endtask

    // Scoreboard monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            sb_big.delete();
            sb_small.delete();
            for (int k = 0; k < 2; k++) begin
                in_fr[k] = 1'b0;
                seen[k]  = 1'b0;
                gap[k]   = 0;
            end
        end else begin
            mon(0, b_dv, b_er, b_rxd, b_ovf);
            mon(1, s_dv, s_er, s_rxd, s_ovf);
        end
    end

    // Drive one frame (7x55, D5, random payload/FCS); push expectations
    task automatic send_frame(input int len, input bit to_big, input bit to_small,
                              input int er_idx, input bit x_corrupt, input bit x_inject,
                              input bit expect_out);
        logic [7:0] b;
        logic       e;
        logic [9:0] ent;
        en_big   = to_big;
        en_small = to_small;
        for (int i = 0; i < len; i++) begin
            b   = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'($urandom);
            e   = (i == er_idx);
            ent = {(i == len - 1), e | x_inject,
                   b ^ ((i == len - 1 && x_corrupt) ? 8'h01 : 8'h00)};
            if (expect_out) begin
                if (to_big)   sb_big.push_back(ent);
                if (to_small) sb_small.push_back(ent);
            end
            txd = b; tx_en = 1'b1; tx_er = e;
            @(posedge clk); #1;
        end
        txd = 8'd0; tx_en = 1'b0; tx_er = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb_big.size() != 0 || sb_small.size() != 0 || b_busy || s_busy) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_timeout", 32'(t < 3000), 32'd1);
        repeat (IFG + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; txd = 8'd0; tx_en = 1'b0; tx_er = 1'b0;
        en_big = 1'b0; en_small = 1'b0; corrupt = 1'b0; inject = 1'b0;
        for (int k = 0; k < 2; k++) ovf_pulses[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rx_dv",   32'(b_dv),   32'd0);
        chk("rst_rxd",     32'(b_rxd),  32'd0);
        chk("rst_rx_er",   32'(b_er),   32'd0);
        chk("rst_busy",    32'(b_busy), 32'd0);
        chk("rst_fc",      32'(b_fc),   32'd0);
        chk("rst_dc",      32'(b_dc),   32'd0);
        chk("rst_ovf",     32'(b_ovf),  32'd0);
        chk("rst_s_fc",    32'(s_fc),   32'd0);
        @(posedge clk); #1;

        // 1: single 72-byte frame, latency and counters
        send_frame(72, 1, 0, -1, 0, 0, 1);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_dv && lat < 0) lat = i;
        end
        chk("latency", 32'(lat), 32'd3);
        @(posedge clk); #1;
        wait_drain();
        chk("t1_fc",   32'(b_fc), 32'd1);
        chk("t1_dc",   32'(b_dc), 32'd0);
        chk("t1_s_fc", 32'(s_fc), 32'd0);

        // 2: two frames 12 cycles apart; second waits out the gap
        send_frame(72, 1, 0, -1, 0, 0, 1);
        repeat (12) @(posedge clk);
        #1;
        send_frame(60, 1, 0, -1, 0, 0, 1);
        wait_drain();
        chk("t2_fc", 32'(b_fc), 32'd3);

        // 3: FCS corruption on last byte only
        corrupt = 1'b1;
        send_frame(64, 1, 0, -1, 1, 0, 1);
        wait_drain();
        corrupt = 1'b0;
        chk("t3_fc", 32'(b_fc), 32'd4);

        // 4: 64-entry buffer: 100B frame dropped, 40B frame kept
        send_frame(100, 0, 1, -1, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        send_frame(40, 0, 1, -1, 0, 0, 1);
        wait_drain();
        en_small = 1'b0;
        chk("t4_s_dc",  32'(s_dc), 32'd1);
        chk("t4_s_fc",  32'(s_fc), 32'd1);
        chk("t4_ovf",   32'(ovf_pulses[1]), 32'd1);
        chk("t4_b_fc",  32'(b_fc), 32'd4);
        chk("t4_b_ovf", 32'(ovf_pulses[0]), 32'd0);

        // 5: tx_er on byte 20, then injected rx_er on one frame only
        send_frame(72, 1, 0, 20, 0, 0, 1);
        wait_drain();
        inject = 1'b1;
        send_frame(60, 1, 0, -1, 0, 1, 1);
        wait_drain();
        inject = 1'b0;
        send_frame(60, 1, 0, -1, 0, 0, 1);
        wait_drain();
        chk("t5_fc", 32'(b_fc), 32'd7);

        // 6: reset mid-playback, then a clean frame
        send_frame(64, 1, 0, -1, 0, 0, 1);
        lat = 0;
        while (!b_dv && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_play_started", 32'(b_dv), 32'd1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rx_dv", 32'(b_dv),   32'd0);
        chk("t6_fc",    32'(b_fc),   32'd0);
        chk("t6_dc",    32'(b_dc),   32'd0);
        chk("t6_busy",  32'(b_busy), 32'd0);
        chk("t6_s_dc",  32'(s_dc),   32'd0);
        @(posedge clk); #1;
        send_frame(60, 1, 0, -1, 0, 0, 1);
        wait_drain();
        chk("t6_fc_after", 32'(b_fc), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
